// File: rtl/axis_frame_limit.sv
// axis_frame_limit: AXI4-Stream frame-length limiter with a registered output
// stage. Frames up to the latched limit pass unchanged; longer frames are cut
// at the limit beat (forced tlast, tuser[0]=1) and their tail is discarded.
// A per-frame status pulse reports input length and truncation.
module axis_frame_limit #(
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = 8,
  parameter bit DEST_ENABLE = 1'b0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_WIDTH  = 1,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  input  logic [LEN_WIDTH-1:0]  max_len,
  output logic                  stat_valid,
  output logic [LEN_WIDTH-1:0]  stat_frame_len,
  output logic                  stat_trunc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for the first beat of a frame
    PASS = 2'd1,  // mid-frame, forwarding beats
    DROP = 2'd2   // frame was cut, discarding its tail
  } state_t;

  state_t state, state_d;

  logic [LEN_WIDTH-1:0]  cnt;        // beats accepted so far in this frame
  logic [LEN_WIDTH-1:0]  lim;        // limit latched on the first beat
  logic [LEN_WIDTH-1:0]  beat_cnt;   // frame position of the beat being offered
  logic [LEN_WIDTH-1:0]  beat_lim;   // limit that applies to that beat
  logic                  accept;
  logic                  fwd;        // accepted beat goes to the output register
  logic                  cut;        // accepted beat is the truncation point
  logic                  frame_end;  // accepted beat closes the input frame
  logic [USER_WIDTH-1:0] user_d;

  logic [DATA_WIDTH-1:0] m_data;
  logic [KEEP_WIDTH-1:0] m_keep;
  logic                  m_valid;
  logic                  m_last;
  logic [ID_WIDTH-1:0]   m_id;
  logic [DEST_WIDTH-1:0] m_dest;
  logic [USER_WIDTH-1:0] m_user;

  // While dropping nothing is forwarded, so the input never waits on the output.
  assign s_axis_tready = (state == DROP) ? 1'b1 : (!m_valid || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // First beat counts as 1 and uses the live max_len; later beats saturate.
  assign beat_cnt = (state == IDLE) ? LEN_WIDTH'(1)
                  : ((cnt == '1) ? cnt : cnt + LEN_WIDTH'(1));
  assign beat_lim = (state == IDLE) ? max_len : lim;

  // Next-state and per-beat control decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    state_d   = state;
    fwd       = 1'b0;
    cut       = 1'b0;
    frame_end = 1'b0;
    if (accept) begin
      case (state)
        IDLE, PASS: begin
          fwd       = 1'b1;
          frame_end = s_axis_tlast;
          if (s_axis_tlast) begin
            state_d = IDLE;
          end else if (beat_lim != '0 && beat_cnt == beat_lim) begin
            cut     = 1'b1;
            state_d = DROP;
          end else begin
            state_d = PASS;
          end
        end
        DROP: begin
          frame_end = s_axis_tlast;
          if (s_axis_tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The cut beat carries the bad-frame flag in tuser[0]; other bits pass.
  always_comb begin
    user_d = s_axis_tuser;
    if (cut) user_d[0] = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Beat counter and per-frame limit latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      lim <= '0;
    end else if (accept) begin
      cnt <= beat_cnt;
      if (state == IDLE) lim <= max_len;
    end
  end

  // Output register: loads on a forwarded beat, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the output data registers are reset too, so the bus never shows X
    // after reset even though only tvalid qualifies it.
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
      m_id    <= '0;
      m_dest  <= '0;
      m_user  <= '0;
    end else if (fwd) begin
      m_valid <= 1'b1;
      m_data  <= s_axis_tdata;
      m_keep  <= s_axis_tkeep;
      m_last  <= s_axis_tlast || cut;
      m_id    <= s_axis_tid;
      m_dest  <= s_axis_tdest;
      m_user  <= user_d;
    end else if (m_axis_tready) begin
      m_valid <= 1'b0;
    end
  end

  // Per-frame status: pulse after the last input beat, values held until next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_valid     <= 1'b0;
      stat_frame_len <= '0;
      stat_trunc     <= 1'b0;
    end else begin
      stat_valid <= frame_end;
      if (frame_end) begin
        stat_frame_len <= beat_cnt;
        stat_trunc     <= (state == DROP);
      end
    end
  end

  assign m_axis_tdata  = m_data;
  assign m_axis_tkeep  = KEEP_ENABLE ? m_keep : {KEEP_WIDTH{1'b1}};
  assign m_axis_tvalid = m_valid;
  assign m_axis_tlast  = m_last;
  assign m_axis_tid    = ID_ENABLE   ? m_id   : '0;
  assign m_axis_tdest  = DEST_ENABLE ? m_dest : '0;
  assign m_axis_tuser  = m_user;

endmodule
